// File: rtl/jt7759_div_pkg.sv
// jt7759_div_pkg
// Shared types and defaults for the multi-channel ADPCM clock-enable divider.
//   div_st_t : channel state (idle / running / finished one-shot)
//   DEF_*    : default channel count, prescaler ratio and divisor width
//   clog2    : width helper used to size the prescaler counter
package jt7759_div_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} div_st_t;

  localparam int DEF_CH  = 4;
  localparam int DEF_PRE = 4;
  localparam int DEF_DW  = 5;

  // Smallest width w such that 2**w >= value
  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int k = 0; k < 31; k++) begin
      if ((1 << k) < value) w = k + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/jt7759_div_ch.sv
// jt7759_div_ch
// One divider channel: counts prescaled ticks and emits a one-clk strobe
// every (div_act+1) ticks, with enable, phase restart, divisor reload at
// wrap and an optional one-shot mode.
//   clk, rst_n : system clock, asynchronous active-low reset
//   tick       : prescaled tick shared by all channels
//   chen       : channel enable (level)
//   restart    : synchronous phase restart pulse
//   oneshot    : 1 = stop after the first strobe
//   divby      : divisor, sampled on entry to RUN and at each wrap
//   cendec     : registered output strobe
//   done       : one-shot completion flag
module jt7759_div_ch
  import jt7759_div_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic          chen,
  input  logic          restart,
  input  logic          oneshot,
  input  logic [DW-1:0] divby,
  output logic          cendec,
  output logic          done
);

  div_st_t       r_state;
  div_st_t       w_stateNext;
  logic [DW-1:0] r_cntDiv;
  logic [DW-1:0] r_divAct;
  logic          r_cendec;
  logic          r_done;
  logic [DW-1:0] w_cntNext;
  logic [DW-1:0] w_actNext;
  logic          w_strobeNext;
  logic          w_doneNext;
  logic          w_wrap;

  assign w_wrap = tick && (r_cntDiv == r_divAct);

  // State register; the datapath registers ride along with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_cntDiv <= '0;
      r_divAct <= '0;
      r_cendec <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_cntDiv <= w_cntNext;
      r_divAct <= w_actNext;
      r_cendec <= w_strobeNext;
      r_done   <= w_doneNext;
    end
  end

  // Next state: disable beats restart, restart beats normal progress
  always_comb begin
    w_stateNext = r_state;
    if (!chen) begin
      w_stateNext = ST_IDLE;
    end else if (restart) begin
      w_stateNext = ST_RUN;
    end else begin
      case (r_state)
        ST_IDLE: w_stateNext = ST_RUN;
        ST_RUN:  if (w_wrap && oneshot) w_stateNext = ST_DONE;
        default: w_stateNext = r_state;
      endcase
    end
  end

  // Datapath and output strobes. The divisor is only reloaded at a wrap
  // (or on entry to RUN), so a divisor change never cuts a period short.
  // A restart swallows any tick landing in the same clk.
  always_comb begin
    w_cntNext    = r_cntDiv;
    w_actNext    = r_divAct;
    w_strobeNext = 1'b0;
    w_doneNext   = r_done;
    if (!chen) begin
      w_cntNext  = '0;
      w_doneNext = 1'b0;
    end else if (restart) begin
      w_cntNext  = '0;
      w_actNext  = divby;
      w_doneNext = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_cntNext = '0;
          w_actNext = divby;
        end
        ST_RUN: begin
          if (w_wrap) begin
            w_cntNext    = '0;
            w_actNext    = divby;
            w_strobeNext = 1'b1;
            if (oneshot) w_doneNext = 1'b1;
          end else if (tick) begin
            w_cntNext = r_cntDiv + DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign cendec = r_cendec;
  assign done   = r_done;

endmodule

// File: rtl/jt7759_div_mc.sv
// jt7759_div_mc
// Multi-channel clock-enable divider for the ADPCM decoder clock tree.
// A shared prescaler divides cen by PRE; each channel divides the
// resulting tick by its own (divby+1).
//   clk, rst_n : system clock, asynchronous active-low reset
//   cen        : input clock enable, one clk wide
//   chen       : per-channel enable
//   restart    : per-channel phase restart pulse
//   oneshot    : per-channel one-shot mode
//   divby      : packed per-channel divisors, channel i at [i*DW +: DW]
//   cendec     : per-channel one-clk output strobes
//   done       : per-channel one-shot completion flags
module jt7759_div_mc
  import jt7759_div_pkg::*;
#(
  parameter int CH  = DEF_CH,
  parameter int PRE = DEF_PRE,
  parameter int DW  = DEF_DW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic [CH-1:0]    chen,
  input  logic [CH-1:0]    restart,
  input  logic [CH-1:0]    oneshot,
  input  logic [CH*DW-1:0] divby,
  output logic [CH-1:0]    cendec,
  output logic [CH-1:0]    done
);

  localparam int PW = (PRE > 1) ? clog2(PRE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);

  logic [PW-1:0] r_cntPre;
  logic          w_tick;

  // Shared prescaler; channel controls never touch its phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cntPre <= '0;
    end else if (cen) begin
      r_cntPre <= (r_cntPre == PRE_LAST) ? '0 : r_cntPre + PW'(1);
    end
  end

  assign w_tick = cen && (r_cntPre == PRE_LAST);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    jt7759_div_ch #(
      .DW(DW)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (w_tick),
      .chen   (chen[i]),
      .restart(restart[i]),
      .oneshot(oneshot[i]),
      .divby  (divby[i*DW +: DW]),
      .cendec (cendec[i]),
      .done   (done[i])
    );
  end

endmodule

// File: tb/tb_jt7759_div_mc.sv
// tb_jt7759_div_mc
// Self-checking bench for jt7759_div_mc: directed scenarios followed by
// random traffic, all compared against a countdown-based reference model.
module tb_jt7759_div_mc;

  localparam int CH  = 4;
  localparam int PRE = 4;
  localparam int DW  = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cen = 1'b0;
  logic [CH-1:0]    chen = '0;
  logic [CH-1:0]    restart = '0;
  logic [CH-1:0]    oneshot = '0;
  logic [CH*DW-1:0] divby = '0;
  logic [CH-1:0]    cendec;
  logic [CH-1:0]    done;

  int checks = 0;
  int errors = 0;

  // Reference model: total cen count since reset gives the prescaler phase;
  // each channel keeps the number of ticks left until its next strobe.
  int            cenCount;
  bit            mRun [CH];
  bit            mFin [CH];
  int            mLeft [CH];
  logic [CH-1:0] expCendec;
  logic [CH-1:0] expDone;
  bit            lastTick;
  int            last0;
  int            iv0 [$];

  jt7759_div_mc #(.CH(CH), .PRE(PRE), .DW(DW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cen    (cen),
    .chen   (chen),
    .restart(restart),
    .oneshot(oneshot),
    .divby  (divby),
    .cendec (cendec),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    cenCount  = 0;
    expCendec = '0;
    expDone   = '0;
    last0     = -1;
    for (int i = 0; i < CH; i++) begin
      mRun[i]  = 1'b0;
      mFin[i]  = 1'b0;
      mLeft[i] = 0;
    end
  endtask

  // Advances the model by one clk using the inputs about to be sampled
  task automatic modelStep();
    bit tk;
    int d;
    tk = cen && ((cenCount % PRE) == PRE - 1);
    lastTick = tk;
    if (cen) cenCount++;
    for (int i = 0; i < CH; i++) begin
      d = int'(divby[i*DW +: DW]);
      expCendec[i] = 1'b0;
      if (!chen[i]) begin
        mRun[i] = 1'b0;
        mFin[i] = 1'b0;
      end else if (restart[i]) begin
        mRun[i]  = 1'b1;
        mFin[i]  = 1'b0;
        mLeft[i] = d + 1;
      end else if (!mRun[i] && !mFin[i]) begin
        mRun[i]  = 1'b1;
        mLeft[i] = d + 1;
      end else if (mRun[i] && tk) begin
        mLeft[i]--;
        if (mLeft[i] == 0) begin
          expCendec[i] = 1'b1;
          mLeft[i] = d + 1;
          if (oneshot[i]) begin
            mRun[i] = 1'b0;
            mFin[i] = 1'b1;
          end
        end
      end
      expDone[i] = mFin[i];
    end
  endtask

  // One clk of stimulus with cen/restart pulses, checked one ns after the edge
  task automatic applyStimulus(input bit c, input logic [CH-1:0] rs);
    cen     = c;
    restart = rs;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("cendec", 32'(cendec), 32'(expCendec));
    checkOutput("done", 32'(done), 32'(expDone));
    if (cendec[0]) begin
      if (last0 >= 0) iv0.push_back(cenCount - last0);
      last0 = cenCount;
    end
    cen     = 1'b0;
    restart = '0;
  endtask

  initial begin
    int cnt;
    int cntB;
    int expB;
    int coinObs;
    int coinExp;
    bit found;

    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_cendec", 32'(cendec), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: channel 0, divisor 4, cen every 16 clk
    chen = 4'b0001;
    divby[0*DW +: DW] = 5'd4;
    iv0.delete();
    for (int k = 0; k < 16 * 65; k++) applyStimulus(k % 16 == 0, '0);
    checkOutput("t1_nper", 32'(iv0.size() >= 2), 32'd1);
    foreach (iv0[j]) checkOutput("t1_period", iv0[j], 32'd20);

    // Scenario 2: divisor 4 -> 1 after two ticks of a period
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (mLeft[0] == 3) found = 1'b1;
      else applyStimulus(k % 2 == 0, '0);
    end
    checkOutput("t2_find", 32'(found), 32'd1);
    divby[0*DW +: DW] = 5'd1;
    iv0.delete();
    for (int k = 0; k < 400 && iv0.size() < 3; k++) applyStimulus(k % 2 == 0, '0);
    checkOutput("t2_count", 32'(iv0.size() >= 3), 32'd1);
    if (iv0.size() >= 3) begin
      checkOutput("t2_old_period", iv0[0], 32'd20);
      checkOutput("t2_new_period", iv0[1], 32'd8);
      checkOutput("t2_new_period2", iv0[2], 32'd8);
    end

    // Scenario 3: one-shot on channel 1 with divisor 2, then restart
    oneshot[1] = 1'b1;
    divby[1*DW +: DW] = 5'd2;
    chen[1] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      applyStimulus(k % 2 == 0, '0);
      if (cendec[1]) cnt++;
    end
    checkOutput("t3_one_strobe", cnt, 32'd1);
    checkOutput("t3_done_held", 32'(done[1]), 32'd1);
    applyStimulus(1'b0, 4'b0010);
    checkOutput("t3_done_clear", 32'(done[1]), 32'd0);
    cnt = 0;
    for (int k = 0; k < 80; k++) begin
      applyStimulus(k % 2 == 0, '0);
      if (cendec[1]) cnt++;
    end
    checkOutput("t3_restart_strobe", cnt, 32'd1);
    checkOutput("t3_done_again", 32'(done[1]), 32'd1);

    // Scenario 4: restart on channel 2 coinciding with its wrap tick
    divby[2*DW +: DW] = 5'd3;
    chen[2] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (mRun[2] && mLeft[2] == 1 && (cenCount % PRE) == PRE - 1) found = 1'b1;
      else applyStimulus(k % 2 == 0, '0);
    end
    checkOutput("t4_find", 32'(found), 32'd1);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("t4_suppressed", 32'(cendec[2]), 32'd0);
    cnt = 0;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      applyStimulus(k % 2 == 0, '0);
      if (lastTick) cnt++;
      if (cendec[2]) found = 1'b1;
    end
    checkOutput("t4_ticks_to_strobe", cnt, 32'd4);

    // Scenario 5: divisor 0 and 31 side by side
    chen = 4'b1001;
    oneshot = '0;
    divby[0*DW +: DW] = 5'd0;
    divby[3*DW +: DW] = 5'd31;
    cntB = 0; expB = 0; coinObs = 0; coinExp = 0;
    for (int k = 0; k < 600; k++) begin
      applyStimulus(k % 2 == 0, '0);
      if (cendec[3]) cntB++;
      if (expCendec[3]) expB++;
      if (cendec[0] && cendec[3]) coinObs++;
      if (expCendec[0] && expCendec[3]) coinExp++;
    end
    checkOutput("t5_slow_count", cntB, expB);
    checkOutput("t5_coincident", coinObs, coinExp);
    checkOutput("t5_slow_seen", 32'(expB >= 1), 32'd1);

    // Scenario 6: asynchronous reset mid-period
    chen = 4'b1011;
    oneshot[1] = 1'b1;
    divby[1*DW +: DW] = 5'd2;
    for (int k = 0; k < 80; k++) applyStimulus(k % 2 == 0, '0);
    checkOutput("t6_pre_done", 32'(done[1]), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_cendec", 32'(cendec), 32'h0);
    checkOutput("t6_rst_done", 32'(done), 32'h0);
    modelReset();
    chen = 4'b0001;
    oneshot = '0;
    divby = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, '0);
    cnt = -1;
    for (int k = 0; k < 40 && cnt < 0; k++) begin
      applyStimulus(k % 2 == 0, '0);
      if (cendec[0]) cnt = cenCount;
    end
    checkOutput("t6_first_strobe_cen", cnt, 32'd4);

    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      logic [CH-1:0] rs;
      rs = '0;
      if ($urandom_range(0, 39) == 0) chen[$urandom_range(0, CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) oneshot[$urandom_range(0, CH - 1)] ^= 1'b1;
      if ($urandom_range(0, 29) == 0) divby[$urandom_range(0, CH - 1)*DW +: DW] = DW'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) rs[$urandom_range(0, CH - 1)] = 1'b1;
      applyStimulus($urandom_range(0, 1) == 1, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt7759_div_mc.md
Name: jt7759_div_mc

Overview:
Multi-channel, parametrised clock-enable divider for the ADPCM decoder clock tree.
- One shared prescaler divides the 640 kHz cen by PRE.
- CH independent channels each divide the prescaled tick by (divby+1) and emit one-clk cendec strobes.
- Adds what the single-channel divider lacks: per-channel enable, synchronous phase restart, glitch-free divisor reload at wrap, and one-shot mode.

Parameters:
- CH, 4, number of divider channels (1..8)
- PRE, 4, prescaler ratio in cen pulses (1..16)
- DW, 5, divisor width per channel

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  input clock enable (640 kHz nominal), one clk wide
- chen  in  CH  per-channel enable (level)
- restart  in  CH  per-channel synchronous phase restart (one clk pulse)
- oneshot  in  CH  per-channel mode: 1 = stop after first strobe, 0 = continuous
- divby  in  CH*DW  per-channel divisor; channel i uses bits [i*DW +: DW]
- cendec  out  CH  per-channel output strobe, one clk wide
- done  out  CH  per-channel one-shot completion flag (level)

Behaviour:
Reset (rst_n low, async):
- cnt_pre = 0; every channel is IDLE with cntdiv = 0 and div_act = 0.
- cendec = 0 and done = 0.

Prescaler:
- On cen: cnt_pre <= (cnt_pre == PRE-1) ? 0 : cnt_pre+1.
- tick = cen && cnt_pre == PRE-1 (combinational).
- The prescaler is never restarted by channel controls.

Channel state machine, states IDLE, RUN, DONE. Priority per clk, highest first:
1. chen[i] = 0 -> IDLE; cntdiv <= 0; done <= 0; no strobe.
2. restart[i] = 1 (chen = 1) -> RUN; cntdiv <= 0; div_act <= divby[i]; done <= 0; cendec suppressed that clk even if tick.
3. IDLE and chen = 1 -> RUN; div_act <= divby[i]; cntdiv <= 0.
4. RUN and tick:
   - If cntdiv == div_act: cntdiv <= 0, div_act <= divby[i] (new divisor only loaded at wrap), cendec[i] <= 1.
   - If additionally oneshot[i] = 1: go to DONE, done <= 1.
   - Otherwise: cntdiv <= cntdiv+1.
5. DONE: counter frozen, no strobes; leave only via restart or chen low.

Output timing:
- cendec is registered: high exactly one clk, on the clk after the cen edge whose tick wraps the channel. Zero otherwise.
- Period in RUN = PRE*(div_act+1) cen pulses.
- First strobe after entering RUN arrives after (div_act+1) ticks. The first tick may come early because the prescaler phase is shared.

Boundary conditions:
- divby = 0: strobe on every tick.
- divby = all ones: period PRE*2^DW, no overflow; cntdiv is DW bits.
- divby changes mid-period: the current period completes with the old value; the new value applies from the next period.
- oneshot changes while in RUN: sampled at the wrap.
- Channels are fully independent; simultaneous wraps produce simultaneous strobes.
- rst_n asserted mid-period: all state clears immediately; outputs are 0 the same cycle.
- cen absent: nothing advances except restart/chen handling.

Decomposition:
- Package jt7759_div_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} div_st_t
  - localparam defaults for CH/PRE/DW
  - function clog2 for the prescaler width
- Sub-module jt7759_div_ch: one channel (state machine, cntdiv, div_act, cendec/done registers).
  - Inputs: tick, chen, restart, oneshot, divby.
  - The top holds the prescaler and a generate loop of CH instances.

Test Plan:
1. Reset, CH=4, PRE=4, chen=4'b0001, divby0=4, cen every 16 clk -> cendec[0] every 20 cen pulses; other channels stay 0; each strobe is one clk wide, one clk after cen.
2. divby0 changed 4->1 mid-period at cntdiv=2 -> the current period ends at 20 cen; following periods are 8 cen.
3. oneshot[1]=1, divby1=2, chen[1] rises -> exactly one cendec[1] after 3 ticks; done[1]=1 and held; restart[1] pulse -> done clears and a new single strobe follows after 3 ticks.
4. restart[2] asserted on the same clk as a wrap tick -> no strobe that cycle; next strobe after divby2+1 ticks.
5. divby=0 and divby=31 on two channels simultaneously -> strobe every 4 cen and every 128 cen respectively; coincident strobes both appear.
6. rst_n pulled low mid-period, async to clk -> cendec/done go 0 immediately; after release, counting restarts from cnt_pre=0 and cntdiv=0.
